// File: rtl/acc_fifo.sv
// Circular-buffer FIFO between the router and one accelerator: registered read data, occupancy count, sticky drop flags.
// One-edge latency for push and pop. A write to a full FIFO is dropped unless a pop frees a slot on the same edge.
module acc_fifo #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              put_req_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              get_req_i,
  output logic [WIDTH-1:0]  data_out_o,
  output logic              data_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              wr_en, rd_en;

  // A pop on the same edge frees the slot a full FIFO needs for the push.
  assign wr_en = put_req_i && (!full_q || get_req_i);
  assign rd_en = get_req_i && !empty_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_en) begin
        rd_ptr_d     = rd_ptr_q + ADDR_W'(1);
        data_out_d   = mem_q[rd_ptr_q];
        data_valid_d = 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
      if (put_req_i && !wr_en) overflow_d  = 1'b1;
      if (get_req_i && !rd_en) underflow_d = 1'b1;
    end
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en && !clear_i) mem_q[wr_ptr_q] <= data_in_i;
  end

  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_acc_fifo.sv
// Randomized and directed bench for acc_fifo against a queue-based reference model.
module tb_acc_fifo;
  localparam int WIDTH  = 128;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear, put_req, get_req;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid, full, empty, overflow, underflow;
  logic [ADDR_W:0]   count;

  acc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .put_req_i(put_req),
    .data_in_i(data_in), .get_req_i(get_req), .data_out_o(data_out),
    .data_valid_o(data_valid), .full_o(full), .empty_o(empty),
    .count_o(count), .overflow_o(overflow), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_dv, exp_ovf, exp_unf;

  function automatic logic [WIDTH-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void model_reset();
    mq.delete();
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endfunction

  function automatic void model_step(input logic p, input logic g, input logic c, input logic [WIDTH-1:0] d);
    int  n;
    logic rd, wr;
    if (c) begin
      mq.delete();
      exp_dv  = 1'b0;
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      return;
    end
    n  = mq.size();
    rd = g && (n > 0);
    wr = p && ((n < DEPTH) || g);
    if (g && !rd) exp_unf = 1'b1;
    if (p && !wr) exp_ovf = 1'b1;
    exp_dv = rd;
    if (rd) exp_dout = mq.pop_front();
    if (wr) mq.push_back(d);
  endfunction

  // Drives one cycle of stimulus, advances the model, and leaves time just past the edge for sampling.
  task automatic cyc(input logic p, input logic g, input logic c, input logic [WIDTH-1:0] d);
    @(negedge clk);
    put_req = p; get_req = g; clear = c; data_in = d;
    @(posedge clk);
    model_step(p, g, c, d);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || data_valid !== 1'b0 ||
        data_out !== '0 || overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_initial: count=%0d empty=%b full=%b dv=%b ovf=%b unf=%b required 0/1/0/0/0/0",
               count, empty, full, data_valid, overflow, underflow);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    cyc(1'b1, 1'b1, 1'b0, rnd_word());
    cyc(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (count !== 4'd3 || data_valid !== 1'b0) $display("FAIL reset_pre: count=%0d required 3", count);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (count !== 0 || empty !== 1'b1 || data_out !== '0 || full !== 1'b0)
      $display("FAIL reset_async: count=%0d empty=%b data_out=%h required 0/1/0", count, empty, data_out);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 128'h77);
    n_checks++;
    if (count !== 4'd1 || data_valid !== 1'b0 || underflow !== 1'b1)
      $display("FAIL reset_first_edge: count=%0d dv=%b unf=%b required 1/0/1", count, data_valid, underflow);
    else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(i));
    n_checks++;
    if (full !== 1'b1 || count !== 4'd8) $display("FAIL fill: full=%b count=%0d required 1/8", full, count);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (data_out !== WIDTH'(i) || data_valid !== 1'b1)
        $display("FAIL drain_%0d: data_out=%h dv=%b required %h/1", i, data_out, data_valid, WIDTH'(i));
      else n_pass++;
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 0) $display("FAIL drain_empty: empty=%b count=%0d required 1/0", empty, count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (data_out !== exp_dout) $display("FAIL wrap_pre_%0d: data_out=%h required %h", i, data_out, exp_dout);
      else n_pass++;
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(8'hA0 + i));
    n_checks++;
    if (full !== 1'b1) $display("FAIL wrap_full: full=%b required 1", full);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (data_out !== WIDTH'(8'hA0 + i) || data_valid !== 1'b1)
        $display("FAIL wrap_%0d: data_out=%h required %h", i, data_out, WIDTH'(8'hA0 + i));
      else n_pass++;
    end
    n_checks++;
    if (count !== 0 || overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL wrap_end: count=%0d ovf=%b unf=%b required 0/0/0", count, overflow, underflow);
    else n_pass++;
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(i));
    cyc(1'b1, 1'b1, 1'b0, 128'h99);
    n_checks++;
    if (data_out !== 128'h1 || full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0)
      $display("FAIL full_simul: data_out=%h full=%b count=%0d ovf=%b required 1/1/8/0", data_out, full, count, overflow);
    else n_pass++;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (data_out !== 128'h99 || empty !== 1'b1)
      $display("FAIL full_simul_last: data_out=%h empty=%b required 99/1", data_out, empty);
    else n_pass++;
  endtask

  task automatic test_errors();
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, WIDTH'(i));
    cyc(1'b1, 1'b0, 1'b0, 128'h9);
    n_checks++;
    if (overflow !== 1'b1 || count !== 4'd8) $display("FAIL overflow: ovf=%b count=%0d required 1/8", overflow, count);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      n_checks++;
      if (data_out !== WIDTH'(i)) $display("FAIL ovf_drain_%0d: data_out=%h required %h", i, data_out, WIDTH'(i));
      else n_pass++;
    end
    cyc(1'b0, 1'b1, 1'b0, '0);
    n_checks++;
    if (underflow !== 1'b1 || data_valid !== 1'b0 || data_out !== 128'h8 || overflow !== 1'b1)
      $display("FAIL underflow: unf=%b dv=%b data_out=%h ovf=%b required 1/0/8/1", underflow, data_valid, data_out, overflow);
    else n_pass++;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, WIDTH'(i));
    n_checks++;
    if (underflow !== 1'b1 || overflow !== 1'b1) $display("FAIL sticky: unf=%b ovf=%b required 1/1", underflow, overflow);
    else n_pass++;
    cyc(1'b0, 1'b0, 1'b1, '0);
    n_checks++;
    if (underflow !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1)
      $display("FAIL err_clear: unf=%b ovf=%b empty=%b required 0/0/1", underflow, overflow, empty);
    else n_pass++;
  endtask

  task automatic test_clear();
    cyc(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, rnd_word());
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, rnd_word());
    n_checks++;
    if (count !== 4'd5 || underflow !== 1'b1) $display("FAIL clear_pre: count=%0d unf=%b required 5/1", count, underflow);
    else n_pass++;
    cyc(1'b1, 1'b1, 1'b1, rnd_word());
    n_checks++;
    if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || data_valid !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0 || data_out !== exp_dout)
      $display("FAIL clear_prio: count=%0d empty=%b dv=%b ovf=%b unf=%b data_out=%h required 0/1/0/0/0/%h",
               count, empty, data_valid, overflow, underflow, data_out, exp_dout);
    else n_pass++;
  endtask

  task automatic test_random();
    logic p, g, c;
    for (int i = 0; i < 600; i++) begin
      p = ($urandom_range(0, 99) < 55);
      g = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 2);
      cyc(p, g, c, rnd_word());
      n_checks++;
      if (data_out !== exp_dout || data_valid !== exp_dv || count !== (ADDR_W+1)'(mq.size()) ||
          full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
          overflow !== exp_ovf || underflow !== exp_unf)
        $display("FAIL random_%0d: dout=%h dv=%b cnt=%0d ovf=%b unf=%b required dout=%h dv=%b cnt=%0d ovf=%b unf=%b",
                 i, data_out, data_valid, count, overflow, underflow,
                 exp_dout, exp_dv, mq.size(), exp_ovf, exp_unf);
      else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; put_req = 1'b0; get_req = 1'b0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_errors();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
